vedio_cap_pack: RTL and testbench

Parametrised, single-clock successor to the fixed-format capture stage. It packs a byte-serial source stream (SRC_CHN channels per pixel, 1..4) into one wide pixel word per strobe, tracks x/y position, and flags malformed lines and frames. It sits between `vedio_src` and the processing chain. It feeds `vedio_store` or any downstream filter with `cap_vld`-qualified pixels instead of a divided clock.

---
 rtl/vedio_cap_pack_pkg.sv | 21 ++
 rtl/vedio_edge_det.sv | 25 ++
 rtl/vedio_cap_pack.sv | 164 ++++++++++++++++
 tb/tb_vedio_cap_pack.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vedio_cap_pack_pkg.sv
// Shared constants and helpers for the video capture/pack slice.
// No logic of its own; elaboration-time values only.
// Not applicable (no datapath).
package vedio_cap_pack_pkg;

    // Widest pixel the packer supports, in channel bytes
    localparam int CHN_MAX       = 4;

    // Channel placement inside the packed pixel word
    localparam int ORD_MSB_FIRST = 0;
    localparam int ORD_LSB_FIRST = 1;

    // Ceiling log2, never below 1 so derived buses stay at least 1 bit wide
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vedio_edge_det.sv
// Rise/fall detector with a one-cycle delayed copy of a 1-bit sync input.
// Latency: rise/fall combinational from sig vs last sample; dly is 1 cycle.
// No backpressure; samples every clock.
module vedio_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall,
    output logic dly
);

    logic r_dly;

    // Remember last cycle's sample of the sync input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_dly <= 1'b0;
        else     r_dly <= sig;
    end

    assign rise = sig & ~r_dly;
    assign fall = ~sig & r_dly;
    assign dly  = r_dly;

endmodule

// File: rtl/vedio_cap_pack.sv
// Packs a byte-serial video stream into pixel words with x/y tracking and line/frame error flags.
// Latency: pixel outputs 1 cycle after the last channel byte; errors 1 cycle after detection.
// No backpressure: one pixel every SRC_CHN cycles, sink must always accept.
module vedio_cap_pack
    import vedio_cap_pack_pkg::*;
#(
    parameter int SRC_DW    = 8,
    parameter int SRC_CHN   = 3,
    parameter int IW        = 640,
    parameter int IH        = 480,
    parameter int CHN_ORDER = 0,
    localparam int PW       = SRC_DW * SRC_CHN,
    localparam int XW       = clog2(IW),
    localparam int YW       = clog2(IH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_hsync,
    input  logic              src_vsync,
    input  logic [SRC_DW-1:0] src_data,
    output logic              cap_vld,
    output logic [PW-1:0]     cap_data,
    output logic [XW-1:0]     cap_x,
    output logic [YW-1:0]     cap_y,
    output logic              cap_sof,
    output logic              cap_eol,
    output logic              cap_hsync,
    output logic              cap_vsync,
    output logic              err_line,
    output logic              err_frame
);

    localparam int            CW       = clog2(CHN_MAX);
    localparam logic [CW-1:0] CHN_LAST = CW'(SRC_CHN - 1);
    // Counters are one bit wider than the coordinate so they can sit at IW / IH
    localparam logic [XW:0]   X_END    = IW[XW:0];
    localparam logic [XW:0]   X_LAST   = X_END - 1'b1;
    localparam logic [YW:0]   Y_END    = IH[YW:0];

    logic w_hs_fall, w_vs_rise, w_unused_hs_rise, w_unused_vs_fall;

    vedio_edge_det u_hs_edge (
        .clk (clk), .rst (rst), .sig (src_hsync),
        .rise(w_unused_hs_rise), .fall(w_hs_fall), .dly(cap_hsync)
    );

    vedio_edge_det u_vs_edge (
        .clk (clk), .rst (rst), .sig (src_vsync),
        .rise(w_vs_rise), .fall(w_unused_vs_fall), .dly(cap_vsync)
    );

    logic [CW-1:0] r_chn_cnt;
    logic [XW:0]   r_x_cnt;
    logic [YW:0]   r_y_cnt;
    logic          r_armed;     // hsync seen low since reset: a mid-line reset drops the rest of that line
    logic          r_x_ovf;     // a pixel beyond IW completed on this line
    logic          r_ovf_seen;  // overflow line already reported in this frame
    logic          r_cap_vld, r_cap_sof, r_cap_eol, r_err_line, r_err_frame;
    logic [PW-1:0] r_cap_data;
    logic [XW-1:0] r_cap_x;
    logic [YW-1:0] r_cap_y;

    logic          w_byte_ok, w_last, w_pix, w_x_in, w_y_in, w_emit, w_ovf, w_short;
    logic [YW:0]   w_y_line;
    logic [PW-1:0] w_sr_next;

    // Pixel word as it stands once the current byte is shifted in
    generate
        if (SRC_CHN == 1) begin : g_single
            assign w_sr_next = src_data;
        end else begin : g_shift
            logic [PW-SRC_DW-1:0] r_sr;
            if (CHN_ORDER == ORD_LSB_FIRST) begin : g_lsb
                assign w_sr_next = {src_data, r_sr};
            end else begin : g_msb
                assign w_sr_next = {r_sr, src_data};
            end
            // Keep the bytes already received for the pixel in flight
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sr <= '0;
                end else if (w_byte_ok) begin
                    if (CHN_ORDER == ORD_LSB_FIRST) r_sr <= w_sr_next[PW-1:SRC_DW];
                    else                            r_sr <= w_sr_next[PW-SRC_DW-1:0];
                end
            end
        end
    endgenerate

    // Decode byte acceptance, pixel completion and error conditions
    always_comb begin
        w_byte_ok = src_hsync & r_armed;
        w_last    = (r_chn_cnt == CHN_LAST);
        w_pix     = w_byte_ok & w_last;
        w_x_in    = (r_x_cnt < X_END);
        w_y_in    = (r_y_cnt < Y_END);
        w_emit    = w_pix & w_x_in & w_y_in;
        w_y_line  = (w_hs_fall && w_y_in) ? r_y_cnt + 1'b1 : r_y_cnt;
        w_ovf     = w_byte_ok & ~w_y_in & ~r_ovf_seen;
        // Short-frame check sees the line that may have ended in this same cycle
        w_short   = w_vs_rise & (w_y_line != '0) & (w_y_line != Y_END);
    end

    // Position counters; a vsync edge overrides the line-end update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chn_cnt  <= '0;
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_armed    <= 1'b0;
            r_x_ovf    <= 1'b0;
            r_ovf_seen <= 1'b0;
        end else begin
            r_armed <= r_armed | ~src_hsync;
            if (w_vs_rise || w_hs_fall) begin
                r_chn_cnt <= '0;
                r_x_cnt   <= '0;
                r_x_ovf   <= 1'b0;
            end else if (w_byte_ok) begin
                r_chn_cnt <= w_last ? '0 : r_chn_cnt + 1'b1;
                if (w_pix && w_x_in)  r_x_cnt <= r_x_cnt + 1'b1;
                if (w_pix && !w_x_in) r_x_ovf <= 1'b1;
            end
            r_y_cnt <= w_vs_rise ? '0 : w_y_line;
            if (w_vs_rise)                   r_ovf_seen <= 1'b0;
            else if (w_byte_ok && !w_y_in)   r_ovf_seen <= 1'b1;
        end
    end

    // Registered pixel and error outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_vld   <= 1'b0;
            r_cap_sof   <= 1'b0;
            r_cap_eol   <= 1'b0;
            r_cap_data  <= '0;
            r_cap_x     <= '0;
            r_cap_y     <= '0;
            r_err_line  <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_cap_vld <= w_emit;
            r_cap_sof <= w_emit && r_x_cnt == '0 && r_y_cnt == '0;
            r_cap_eol <= w_emit && r_x_cnt == X_LAST;
            if (w_emit) begin
                r_cap_data <= w_sr_next;
                r_cap_x    <= r_x_cnt[XW-1:0];
                r_cap_y    <= r_y_cnt[YW-1:0];
            end
            r_err_line  <= w_hs_fall & ((r_chn_cnt != '0) | (r_x_cnt != X_END) | r_x_ovf);
            r_err_frame <= w_short | w_ovf;
        end
    end

    assign cap_vld   = r_cap_vld;
    assign cap_sof   = r_cap_sof;
    assign cap_eol   = r_cap_eol;
    assign cap_data  = r_cap_data;
    assign cap_x     = r_cap_x;
    assign cap_y     = r_cap_y;
    assign err_line  = r_err_line;
    assign err_frame = r_err_frame;

endmodule

// File: tb/tb_vedio_cap_pack.sv
module tb_vedio_cap_pack;

    logic        clk, rst, src_hsync, src_vsync;
    logic [7:0]  src_data;
    logic        cap_vld, cap_sof, cap_eol, cap_hsync, cap_vsync, err_line, err_frame;
    logic [23:0] cap_data;
    logic [1:0]  cap_x;
    logic [0:0]  cap_y;
    logic        cap_vld1, cap_sof1, cap_eol1, cap_hsync1, cap_vsync1, err_line1, err_frame1;
    logic [23:0] cap_data1;
    logic [1:0]  cap_x1;
    logic [0:0]  cap_y1;

    vedio_cap_pack #(.SRC_DW(8), .SRC_CHN(3), .IW(4), .IH(2), .CHN_ORDER(0)) dut (
        .clk(clk), .rst(rst), .src_hsync(src_hsync), .src_vsync(src_vsync), .src_data(src_data),
        .cap_vld(cap_vld), .cap_data(cap_data), .cap_x(cap_x), .cap_y(cap_y),
        .cap_sof(cap_sof), .cap_eol(cap_eol), .cap_hsync(cap_hsync), .cap_vsync(cap_vsync),
        .err_line(err_line), .err_frame(err_frame)
    );

    vedio_cap_pack #(.SRC_DW(8), .SRC_CHN(3), .IW(4), .IH(2), .CHN_ORDER(1)) dut1 (
        .clk(clk), .rst(rst), .src_hsync(src_hsync), .src_vsync(src_vsync), .src_data(src_data),
        .cap_vld(cap_vld1), .cap_data(cap_data1), .cap_x(cap_x1), .cap_y(cap_y1),
        .cap_sof(cap_sof1), .cap_eol(cap_eol1), .cap_hsync(cap_hsync1), .cap_vsync(cap_vsync1),
        .err_line(err_line1), .err_frame(err_frame1)
    );

    typedef struct packed {
        logic [23:0] d;
        logic [1:0]  x;
        logic [0:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;

    pix_t        q[$];
    logic [23:0] d1_q[$];
    int          n_eline, n_eframe;
    int          n_vec = 0;
    int          n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe and error-cycle away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (cap_vld)  q.push_back('{cap_data, cap_x, cap_y, cap_sof, cap_eol});
            if (cap_vld1) d1_q.push_back(cap_data1);
            n_eline  += int'(err_line);
            n_eframe += int'(err_frame);
        end
    end

    function automatic pix_t getpix(input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    task automatic clear_mon();
        q.delete();
        d1_q.delete();
        n_eline  = 0;
        n_eframe = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        src_hsync = 1'b1;
        src_data  = b;
    endtask

    task automatic end_line();
        @(posedge clk); #1;
        src_hsync = 1'b0;
        src_data  = 8'h00;
        idle(3);
    endtask

    task automatic send_line(input int nbytes);
        for (int i = 1; i <= nbytes; i++) send_byte(8'(i));
        end_line();
    endtask

    task automatic vs_pulse();
        @(posedge clk); #1;
        src_vsync = 1'b1;
        idle(2); #1;
        src_vsync = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; src_hsync = 1'b0; src_vsync = 1'b0; src_data = 8'h00;
        idle(3); #1;
        n_vec++; if (cap_vld !== 1'b0)    begin n_err++; $display("FAIL rst_vld: got %b want 0", cap_vld); end
        n_vec++; if (cap_data !== 24'h0)  begin n_err++; $display("FAIL rst_data: got %h want 000000", cap_data); end
        n_vec++; if (cap_x !== 2'd0 || cap_y !== 1'd0) begin n_err++; $display("FAIL rst_xy: got %0d,%0d want 0,0", cap_x, cap_y); end
        n_vec++; if (cap_sof !== 1'b0 || cap_eol !== 1'b0) begin n_err++; $display("FAIL rst_sof_eol: got %b%b want 00", cap_sof, cap_eol); end
        n_vec++; if (cap_hsync !== 1'b0 || cap_vsync !== 1'b0) begin n_err++; $display("FAIL rst_sync: got %b%b want 00", cap_hsync, cap_vsync); end
        n_vec++; if (err_line !== 1'b0 || err_frame !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b%b want 00", err_line, err_frame); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_nominal();
        pix_t p;
        clear_mon();
        vs_pulse();
        send_line(12);
        send_line(12);
        n_vec++; if (q.size() !== 8) begin n_err++; $display("FAIL nom_count: got %0d want 8", q.size()); end
        p = getpix(0);
        n_vec++; if (p.d !== 24'h010203 || p.sof !== 1'b1 || p.x !== 2'd0 || p.y !== 1'd0)
            begin n_err++; $display("FAIL nom_first: got d=%h sof=%b x=%0d y=%0d want d=010203 sof=1 x=0 y=0", p.d, p.sof, p.x, p.y); end
        p = getpix(3);
        n_vec++; if (p.d !== 24'h0A0B0C || p.eol !== 1'b1 || p.x !== 2'd3 || p.sof !== 1'b0)
            begin n_err++; $display("FAIL nom_eol: got d=%h eol=%b x=%0d sof=%b want d=0a0b0c eol=1 x=3 sof=0", p.d, p.eol, p.x, p.sof); end
        p = getpix(1);
        n_vec++; if (p.d !== 24'h040506 || p.x !== 2'd1 || p.eol !== 1'b0)
            begin n_err++; $display("FAIL nom_mid: got d=%h x=%0d eol=%b want d=040506 x=1 eol=0", p.d, p.x, p.eol); end
        p = getpix(4);
        n_vec++; if (p.y !== 1'd1 || p.x !== 2'd0 || p.sof !== 1'b0)
            begin n_err++; $display("FAIL nom_line2: got y=%0d x=%0d sof=%b want y=1 x=0 sof=0", p.y, p.x, p.sof); end
        n_vec++; if (n_eline !== 0 || n_eframe !== 0)
            begin n_err++; $display("FAIL nom_errs: got line=%0d frame=%0d want 0 0", n_eline, n_eframe); end
        n_vec++; if (cap_data !== 24'h0A0B0C)
            begin n_err++; $display("FAIL nom_hold: got %h want 0a0b0c", cap_data); end
        n_vec++; if (d1_q.size() !== 8 || d1_q[0] !== 24'h030201)
            begin n_err++; $display("FAIL lsb_first: got n=%0d d=%h want n=8 d=030201", d1_q.size(), (d1_q.size() > 0) ? d1_q[0] : 24'hxxxxxx); end
    endtask

    task automatic test_partial();
        pix_t p;
        clear_mon();
        vs_pulse();
        send_line(11);
        n_vec++; if (q.size() !== 3) begin n_err++; $display("FAIL part_count: got %0d want 3", q.size()); end
        n_vec++; if (n_eline !== 1) begin n_err++; $display("FAIL part_errline: got %0d cycles want 1", n_eline); end
        send_line(12);
        p = getpix(3);
        n_vec++; if (q.size() !== 7) begin n_err++; $display("FAIL part_next_count: got %0d want 7", q.size()); end
        n_vec++; if (p.d !== 24'h010203 || p.x !== 2'd0 || p.y !== 1'd1)
            begin n_err++; $display("FAIL part_next: got d=%h x=%0d y=%0d want d=010203 x=0 y=1", p.d, p.x, p.y); end
        n_vec++; if (n_eline !== 1 || n_eframe !== 0)
            begin n_err++; $display("FAIL part_errs: got line=%0d frame=%0d want 1 0", n_eline, n_eframe); end
    endtask

    task automatic test_long_line();
        pix_t p;
        clear_mon();
        vs_pulse();
        send_line(15);
        p = getpix(3);
        n_vec++; if (q.size() !== 4) begin n_err++; $display("FAIL long_count: got %0d want 4", q.size()); end
        n_vec++; if (p.d !== 24'h0A0B0C || p.eol !== 1'b1)
            begin n_err++; $display("FAIL long_last: got d=%h eol=%b want d=0a0b0c eol=1", p.d, p.eol); end
        n_vec++; if (n_eline !== 1) begin n_err++; $display("FAIL long_errline: got %0d want 1", n_eline); end
        send_line(12);
        send_line(12);
        n_vec++; if (q.size() !== 8) begin n_err++; $display("FAIL ovf_drop: got %0d want 8", q.size()); end
        n_vec++; if (n_eframe !== 1) begin n_err++; $display("FAIL ovf_errframe: got %0d want 1", n_eframe); end
        send_line(12);
        n_vec++; if (n_eframe !== 1 || n_eline !== 1 || q.size() !== 8)
            begin n_err++; $display("FAIL ovf_once: got frame=%0d line=%0d n=%0d want 1 1 8", n_eframe, n_eline, q.size()); end
    endtask

    task automatic test_short_frame();
        pix_t p;
        clear_mon();
        vs_pulse();
        send_line(12);
        n_vec++; if (n_eframe !== 0) begin n_err++; $display("FAIL short_clean: got %0d want 0", n_eframe); end
        vs_pulse();
        n_vec++; if (n_eframe !== 1) begin n_err++; $display("FAIL short_errframe: got %0d want 1", n_eframe); end
        send_line(12);
        p = getpix(4);
        n_vec++; if (p.y !== 1'd0 || p.sof !== 1'b1 || p.x !== 2'd0)
            begin n_err++; $display("FAIL short_restart: got y=%0d sof=%b x=%0d want 0 1 0", p.y, p.sof, p.x); end
    endtask

    task automatic test_reset_midline();
        pix_t p;
        vs_pulse();
        clear_mon();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        @(posedge clk); #1;
        n_vec++; if (cap_hsync !== 1'b1 || cap_data !== 24'h010203 || q.size() !== 1)
            begin n_err++; $display("FAIL prerst: got hs=%b d=%h n=%0d want 1 010203 1", cap_hsync, cap_data, q.size()); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (cap_hsync !== 1'b0 || cap_data !== 24'h0 || cap_x !== 2'd0 || cap_vld !== 1'b0)
            begin n_err++; $display("FAIL async_rst: got hs=%b d=%h x=%0d vld=%b want 0 000000 0 0", cap_hsync, cap_data, cap_x, cap_vld); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        for (int i = 6; i <= 12; i++) send_byte(8'(i));
        end_line();
        n_vec++; if (q.size() !== 0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", q.size()); end
        n_vec++; if (n_eline !== 1) begin n_err++; $display("FAIL rst_errline: got %0d want 1", n_eline); end
        vs_pulse();
        clear_mon();
        send_line(12);
        p = getpix(0);
        n_vec++; if (q.size() !== 4 || p.d !== 24'h010203 || p.sof !== 1'b1)
            begin n_err++; $display("FAIL rst_recover: got n=%0d d=%h sof=%b want 4 010203 1", q.size(), p.d, p.sof); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_partial();
        test_long_line();
        test_short_frame();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
